// File: rtl/mux_scan_nx1.sv
// mux_scan_nx1: N-channel, W-bit multiplexer with a registered output, manual select or round-robin scan
// Latency: 1 clock from sampled din/sel/ch_mask to dout/dout_ch/dout_valid.
// Backpressure: none; en is the only pacing strobe, and dout_valid pulses once per accepted sample.
//
// Ports:
//   clk, rst_n       clock and asynchronous active-low reset
//   din              packed channel data, channel k at din[k*WIDTH +: WIDTH]
//   ch_mask          per-channel eligibility (1 = eligible)
//   sel              manual-mode channel select
//   mode             0 = manual, 1 = scan
//   en               advance/sample strobe
//   dout, dout_ch    registered sample and the channel index it came from
//   dout_valid       one-cycle pulse per accepted sample
// Legal configurations: 2 <= CH <= 256 and 2**SEL_W >= CH.

module mux_scan_nx1 #(
  parameter int WIDTH = 8,
  parameter int CH    = 8,
  parameter int SEL_W = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CH*WIDTH-1:0]   din,
  input  logic [CH-1:0]         ch_mask,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  mode,
  input  logic                  en,
  output logic [WIDTH-1:0]      dout,
  output logic [SEL_W-1:0]      dout_ch,
  output logic                  dout_valid
);

  localparam int               NSLOT = 1 << SEL_W;
  localparam logic [SEL_W:0]   CH_W  = (SEL_W+1)'(CH);
  localparam logic [SEL_W-1:0] CH_M1 = SEL_W'(CH - 1);

  typedef enum logic {
    MANUAL = 1'b0,
    SCAN   = 1'b1
  } state_e;

  state_e              state_q;
  logic [SEL_W-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0]    dout_q, dout_d;
  logic [SEL_W-1:0]    ch_q, ch_d;
  logic                vld_q, vld_d;

  // Zero-padded to the full select range so that any sel value indexes
  // safely; slots >= CH read as masked-off.
  logic [NSLOT-1:0]        mask_ext;
  logic [NSLOT*WIDTH-1:0]  din_ext;

  always_comb begin
    mask_ext = '0;
    mask_ext[CH-1:0] = ch_mask;
    din_ext = '0;
    din_ext[CH*WIDTH-1:0] = din;
  end

  // Round-robin search: first eligible channel at or after ptr, wrapping
  // modulo CH. ptr + i stays below 2*CH, so one conditional subtract wraps.
  logic                found;
  logic [SEL_W-1:0]    cand;
  logic [SEL_W:0]      idx;

  always_comb begin
    found = 1'b0;
    cand  = '0;
    idx   = '0;
    for (int i = 0; i < CH; i++) begin
      idx = {1'b0, ptr_q} + (SEL_W+1)'(i);
      if (idx >= CH_W) idx = idx - CH_W;
      if (!found && mask_ext[idx[SEL_W-1:0]]) begin
        found = 1'b1;
        cand  = idx[SEL_W-1:0];
      end
    end
  end

  // The rule is chosen from the live mode input so the edge that switches
  // modes already samples under the new mode.
  always_comb begin
    ptr_d  = ptr_q;
    dout_d = dout_q;
    ch_d   = ch_q;
    vld_d  = 1'b0;
    if (en) begin
      if (mode) begin
        if (found) begin
          dout_d = din_ext[cand*WIDTH +: WIDTH];
          ch_d   = cand;
          vld_d  = 1'b1;
          ptr_d  = (cand == CH_M1) ? '0 : cand + SEL_W'(1);
        end
      end else if (mask_ext[sel]) begin
        dout_d = din_ext[sel*WIDTH +: WIDTH];
        ch_d   = sel;
        vld_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MANUAL;
      ptr_q   <= '0;
      dout_q  <= '0;
      ch_q    <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= mode ? SCAN : MANUAL;
      ptr_q   <= ptr_d;
      dout_q  <= dout_d;
      ch_q    <= ch_d;
      vld_q   <= vld_d;
    end
  end

  assign dout       = dout_q;
  assign dout_ch    = ch_q;
  assign dout_valid = vld_q;

  // A manual sample is only ever accepted for an in-range channel, and the
  // scan pointer never leaves 0..CH-1.
  a_manual_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    (vld_q && state_q == MANUAL) |-> ({1'b0, ch_q} < CH_W));
  a_ptr_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    ({1'b0, ptr_q} < CH_W));

endmodule
